// File: rtl/sig_control_param.sv
`default_nettype none
// ============================================================================
// Module      : sig_control_param
// Description : Highway / country-road junction controller. A five-state Moore
//               FSM sequences the lights, and one CNT_W-bit down-counter times
//               every state. The timer can hold highway green for a minimum
//               time and can cap how long country green lasts. Illegal state
//               codes show red on both roads and return to S0 on the next
//               clock edge.
// Ports       : clock  - single clock, all logic on the rising edge
//               clear  - synchronous active-high reset
//               X      - country-road car sensor (level, synchronous)
//               hwy    - highway light   (RED=0, YELLOW=1, GREEN=2)
//               cntry  - country light   (same encoding)
//               state  - current FSM state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module sig_control_param #(
    parameter int CNT_W           = 34,
    parameter int Y2R_DELAY       = 300_000_000,
    parameter int R2G_DELAY       = 200_000_000,
    parameter int MIN_HWY_GREEN   = 0,
    parameter int MAX_CNTRY_GREEN = 0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state
);

    // State encodings (these are visible on the debug port)
    localparam logic [2:0] c_S0 = 3'd0;   // GREEN / RED
    localparam logic [2:0] c_S1 = 3'd1;   // YELLOW / RED
    localparam logic [2:0] c_S2 = 3'd2;   // RED / RED
    localparam logic [2:0] c_S3 = 3'd3;   // RED / GREEN
    localparam logic [2:0] c_S4 = 3'd4;   // RED / YELLOW

    localparam logic [1:0] c_RED    = 2'd0;
    localparam logic [1:0] c_YELLOW = 2'd1;
    localparam logic [1:0] c_GREEN  = 2'd2;

    // Entry values loaded into the timer on each state change. A state
    // loaded with N lasts N+1 cycles, because the exit condition is checked
    // in the cycle where the timer reads zero.
    localparam logic [CNT_W-1:0] c_MIN_LOAD = CNT_W'(MIN_HWY_GREEN);
    localparam logic [CNT_W-1:0] c_Y2R_LOAD = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] c_R2G_LOAD = CNT_W'(R2G_DELAY - 1);
    localparam logic [CNT_W-1:0] c_MAX_LOAD =
        (MAX_CNTRY_GREEN != 0) ? CNT_W'(MAX_CNTRY_GREEN - 1) : '0;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam bit               c_HAS_TIMEOUT = (MAX_CNTRY_GREEN != 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] w_entry_load;
    logic             w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S0: if (X && w_timer_zero) w_next_state = c_S1;
            c_S1: if (w_timer_zero)      w_next_state = c_S2;
            c_S2: if (w_timer_zero)      w_next_state = c_S3;
            // A car leaving and a timeout in the same cycle both lead to S4,
            // so the two conditions are simply ORed.
            c_S3: if (!X || (c_HAS_TIMEOUT && w_timer_zero))
                                          w_next_state = c_S4;
            c_S4: if (w_timer_zero)      w_next_state = c_S0;
            default:                      w_next_state = c_S0;
        endcase
    end

    // Timer value for the state being entered
    always_comb begin
        w_entry_load = c_MIN_LOAD;
        case (w_next_state)
            c_S0:    w_entry_load = c_MIN_LOAD;
            c_S1:    w_entry_load = c_Y2R_LOAD;
            c_S2:    w_entry_load = c_R2G_LOAD;
            c_S3:    w_entry_load = c_MAX_LOAD;
            c_S4:    w_entry_load = c_Y2R_LOAD;
            default: w_entry_load = c_MIN_LOAD;
        endcase
    end

    // State and timer registers. While the state is unchanged the timer
    // counts down and stops at zero; it never wraps.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_S0;
            r_timer <= c_MIN_LOAD;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_timer <= w_entry_load;
            end else if (!w_timer_zero) begin
                r_timer <= r_timer - c_ONE;
            end
        end
    end

    // Moore output decode, driven only by the state register. Any code that
    // is not a legal state shows red on both roads.
    always_comb begin
        hwy   = c_RED;
        cntry = c_RED;
        case (r_state)
            c_S0: begin hwy = c_GREEN;  cntry = c_RED;    end
            c_S1: begin hwy = c_YELLOW; cntry = c_RED;    end
            c_S2: begin hwy = c_RED;    cntry = c_RED;    end
            c_S3: begin hwy = c_RED;    cntry = c_GREEN;  end
            c_S4: begin hwy = c_RED;    cntry = c_YELLOW; end
            default: begin hwy = c_RED; cntry = c_RED;    end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sig_control_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sig_control_param
// Description : Self-checking bench for sig_control_param. There are two
//               instances: one with a minimum highway-green hold and a
//               country-green timeout, and one with both features disabled.
//               A model based on how long the FSM has stayed in each state
//               is compared with each instance on every cycle. Directed
//               sequences also check hand-computed state durations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sig_control_param;

    localparam int c_Y2R = 3;
    localparam int c_R2G = 2;
    localparam int c_MIN = 4;
    localparam int c_MAX = 5;

    logic       r_clock = 1'b0;
    logic       r_clear = 1'b0;
    logic       r_x     = 1'b0;
    logic       r_clear_d = 1'b0;
    logic       r_x_d     = 1'b0;
    logic [1:0] w_hwy, w_cntry, w_hwy_d, w_cntry_d;
    logic [2:0] w_state, w_state_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 r_clock = ~r_clock;

    sig_control_param #(
        .CNT_W(8), .Y2R_DELAY(c_Y2R), .R2G_DELAY(c_R2G),
        .MIN_HWY_GREEN(c_MIN), .MAX_CNTRY_GREEN(c_MAX)
    ) dut (
        .clock(r_clock), .clear(r_clear), .X(r_x),
        .hwy(w_hwy), .cntry(w_cntry), .state(w_state)
    );

    sig_control_param #(
        .CNT_W(8), .Y2R_DELAY(c_Y2R), .R2G_DELAY(c_R2G),
        .MIN_HWY_GREEN(0), .MAX_CNTRY_GREEN(0)
    ) dut_d (
        .clock(r_clock), .clear(r_clear_d), .X(r_x_d),
        .hwy(w_hwy_d), .cntry(w_cntry_d), .state(w_state_d)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // age = number of cycles the FSM has spent in the current state,
    // including the current cycle
    function automatic int model_next(input int st, input int age, input bit x,
                                      input int min_g, input int max_g);
        case (st)
            0: return (x && age >= min_g + 1) ? 1 : 0;
            1: return (age >= c_Y2R) ? 2 : 1;
            2: return (age >= c_R2G) ? 3 : 2;
            3: return (!x || (max_g != 0 && age >= max_g)) ? 4 : 3;
            4: return (age >= c_Y2R) ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic int light_hwy(input int st);
        case (st)
            0: return 2;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int light_cntry(input int st);
        case (st)
            3: return 2;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    int m_st = 0, m_age = 0, md_st = 0, md_age = 0;
    bit m_valid = 0, md_valid = 0;

    always @(posedge r_clock) begin
        int ns;
        if (r_clear) begin
            m_st = 0; m_age = 1; m_valid = 1;
        end else if (m_valid) begin
            ns = model_next(m_st, m_age, r_x, c_MIN, c_MAX);
            m_age = (ns != m_st) ? 1 : m_age + 1;
            m_st = ns;
        end
        if (r_clear_d) begin
            md_st = 0; md_age = 1; md_valid = 1;
        end else if (md_valid) begin
            ns = model_next(md_st, md_age, r_x_d, 0, 0);
            md_age = (ns != md_st) ? 1 : md_age + 1;
            md_st = ns;
        end
    end

    // The compare process samples on the falling edge, away from the active edge.
    always @(negedge r_clock) begin
        if (m_valid) begin
            chk("model_state", int'(w_state), m_st);
            chk("model_hwy",   int'(w_hwy),   light_hwy(m_st));
            chk("model_cntry", int'(w_cntry), light_cntry(m_st));
            chk("safety", int'(w_hwy != 2'd0 && w_cntry != 2'd0), 0);
        end
        if (md_valid) begin
            chk("model_d_state", int'(w_state_d), md_st);
            chk("model_d_hwy",   int'(w_hwy_d),   light_hwy(md_st));
            chk("model_d_cntry", int'(w_cntry_d), light_cntry(md_st));
            chk("safety_d", int'(w_hwy_d != 2'd0 && w_cntry_d != 2'd0), 0);
        end
    end

    // ---------------- directed helpers ----------------
    // Called at a falling edge where exp_st is already visible. Counts how
    // many cycles the state stays unchanged and returns at the falling edge
    // where the next state first appears.
    task automatic expect_run(input string name, input bit use_d,
                              input int exp_st, input int exp_len);
        int n = 0;
        while (int'(use_d ? w_state_d : w_state) == exp_st && n < 200) begin
            n++;
            @(negedge r_clock);
        end
        chk(name, n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge r_clock);
        // 1. Reset, then idle with X low
        r_clear = 1'b1;
        @(negedge r_clock);
        r_clear = 1'b0;
        chk("reset_state", int'(w_state), 0);
        chk("reset_hwy",   int'(w_hwy),   2);
        chk("reset_cntry", int'(w_cntry), 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge r_clock);
            chk("idle_state", int'(w_state), 0);
            chk("idle_hwy",   int'(w_hwy),   2);
            chk("idle_cntry", int'(w_cntry), 0);
        end

        // 2. Full cycle with X held high from the release of clear
        r_clear = 1'b1;
        @(negedge r_clock);
        r_clear = 1'b0;
        r_x     = 1'b1;
        expect_run("s2_S0_len", 0, 0, 5);
        expect_run("s2_S1_len", 0, 1, 3);
        expect_run("s2_S2_len", 0, 2, 2);
        expect_run("s2_S3_timeout_len", 0, 3, 5);
        expect_run("s2_S4_len", 0, 4, 3);
        expect_run("s2_S0_again_len", 0, 0, 5);
        chk("s2_reenter_S1", int'(w_state), 1);

        // 3. The car leaves early, in the second cycle of S3
        expect_run("s3_S1_len", 0, 1, 3);
        expect_run("s3_S2_len", 0, 2, 2);
        chk("s3_in_S3", int'(w_state), 3);
        @(negedge r_clock);
        chk("s3_S3_cycle2", int'(w_state), 3);
        r_x = 1'b0;
        @(negedge r_clock);
        chk("s3_early_S4", int'(w_state), 4);
        chk("s3_cntry_yellow", int'(w_cntry), 1);
        expect_run("s3_S4_len", 0, 4, 3);
        chk("s3_back_S0", int'(w_state), 0);

        // 4. Short request in the first two S0 cycles is ignored
        r_x = 1'b1;
        @(negedge r_clock);
        @(negedge r_clock);
        r_x = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge r_clock);
            chk("s4_hold_S0", int'(w_state), 0);
        end
        r_x = 1'b1;
        @(negedge r_clock);
        chk("s4_late_req_S1", int'(w_state), 1);

        // 5. Reset in the second cycle of S1
        @(negedge r_clock);
        chk("s5_S1_cycle2", int'(w_state), 1);
        r_clear = 1'b1;
        @(negedge r_clock);
        r_clear = 1'b0;
        chk("s5_state", int'(w_state), 0);
        chk("s5_hwy",   int'(w_hwy),   2);
        chk("s5_cntry", int'(w_cntry), 0);
        chk("s5_timer", int'(dut.r_timer), 4);
        expect_run("s5_S0_len", 0, 0, 5);
        chk("s5_then_S1", int'(w_state), 1);

        // 6. Default parameters: no hold, no timeout
        r_clear_d = 1'b1;
        @(negedge r_clock);
        r_clear_d = 1'b0;
        r_x_d     = 1'b1;
        expect_run("s6_S0_len", 1, 0, 1);
        expect_run("s6_S1_len", 1, 1, 3);
        expect_run("s6_S2_len", 1, 2, 2);
        for (int i = 0; i < 20; i++) begin
            chk("s6_S3_persist", int'(w_state_d), 3);
            @(negedge r_clock);
        end
        r_x_d = 1'b0;
        @(negedge r_clock);
        chk("s6_S4", int'(w_state_d), 4);
        expect_run("s6_S4_len", 1, 4, 3);
        chk("s6_back_S0", int'(w_state_d), 0);

        @(negedge r_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
